avr_prefetch: RTL and testbench
===============================

AVR_PREFETCH -- requirements
Module: avr_prefetch

Interface
REQ-001 SHALL expose the following parameters:
- ADDR_W, 16, program-word address width.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
REQ-002 SHALL expose the following ports, clock and reset first:
- CLK  in  1  clock.
- RST  in  1  reset: synchronous, active-high.
- prog_req  out  1  program-memory read strobe.
- prog_addr  out  ADDR_W  program-memory word address.
- prog_data  in  16  read data, valid exactly one cycle after prog_req.
- pc_src  in  3  PC control: 000 to zero, 001 hold, 010 +1, 011 +2, 100 relative, 101 absolute, 110/111 illegal.
- jmp  in  ADDR_W  relative offset (caller sign-extends) or absolute target.
- stall  in  1  consumer not ready; head is not popped.
- instr_valid  out  1  head instruction complete and presentable.
- cur_instr  out  16  head word.
- cur_instr2  out  16  second word of a 32-bit instruction.
- cur_long  out  1  head is a 32-bit instruction.
- cur_pc  out  ADDR_W  address of the head word.
- pc_err  out  1  one-cycle pulse when pc_src is 110/111.

Function
REQ-003 Queue SHALL hold up to DEPTH {pc, word} entries; fetch_pc advances by 1 on each issued request.
REQ-004 prog_req SHALL be 1 only when queue occupancy plus in-flight requests is less than DEPTH; the full condition blocks issue.
REQ-005 Each response SHALL be written to the queue tail at the edge ending the cycle after its request.
REQ-006 When the queue is empty, instr_valid SHALL be 0, cur_instr SHALL be 16'h0000 (NOP), and cur_long SHALL be 0.
REQ-007 A pop SHALL occur when instr_valid=1 and stall=0 and pc_src is 010 or 011; the pop removes 1 entry, or 2 when cur_long=1.
REQ-008 pc_src=001, or stall=1 with a non-redirect pc_src, SHALL leave the queue head unchanged; fetching continues until the queue is full.
REQ-009 A redirect occurs when pc_src is 000, 100 or 101 with instr_valid=1. On a redirect:
- The target SHALL be 0, cur_pc+jmp, or jmp respectively.
- The queue SHALL be flushed.
- The in-flight response SHALL be discarded (epoch bit).
- prog_addr SHALL equal the target in that same cycle with prog_req=1.
REQ-010 Redirect latency: redirect in cycle N -> target word in the queue after the N+1 edge; instr_valid=1 in N+2 for a 16-bit target.
REQ-011 A redirect SHALL take priority over a pop, and over a response arriving in the same cycle.
REQ-012 pc_src 110/111 SHALL act as hold and SHALL pulse pc_err for one cycle.
REQ-013 All address arithmetic SHALL be modulo 2^ADDR_W: fetch_pc and targets wrap from all-ones to zero.
REQ-014 Simultaneous pop and push SHALL keep occupancy constant; occupancy SHALL never exceed DEPTH or underflow.

Reset
REQ-015 While RST=1 at a clock edge, the block SHALL set:
- occupancy 0 and in-flight cleared.
- fetch_pc 0 and epoch 0.
REQ-016 Outputs during and after reset: instr_valid=0, cur_instr=0, cur_instr2=0, cur_long=0, cur_pc=0, pc_err=0, prog_req=0.
REQ-017 Reset mid-fetch SHALL drop the outstanding response.
REQ-018 The first request after reset SHALL be address 0, in the cycle after RST falls.

Configuration
REQ-019 With AVR_PREFETCH_LONG_INSTR_EN defined:
- Heads matching 1001010xxxxx11xx (JMP/CALL) or 100100xxxxxx0000 (LDS/STS) SHALL set cur_long=1.
- instr_valid for such a head SHALL require 2 entries, and cur_instr2 SHALL be the second entry.
- pc_src=011 SHALL be accepted.
REQ-020 Without AVR_PREFETCH_LONG_INSTR_EN:
- cur_long and cur_instr2 SHALL be constant 0.
- pc_src=011 SHALL be treated as 010.

Structure
REQ-021 Shared package avr_pkg SHALL hold:
- pc_src encoding constants.
- the NOP constant.
- the 32-bit opcode match patterns.
REQ-022 Queue storage and pointers SHALL be sub-module avr_prefetch_fifo (parameters DEPTH, WIDTH); redirect, epoch and issue logic stay in avr_prefetch.

Verification
REQ-023 Directed scenarios the bench SHALL cover:
- Reset, memory word[i]=i, pc_src=010, stall=0 -> first instr_valid in cycle 2 with cur_pc=0; cur_instr=0,1,2,... on consecutive cycles.
- stall=1 for 10 cycles -> exactly DEPTH requests issued, then prog_req=0; head unchanged; 1 pop on release.
- Redirect at cur_pc=5, pc_src=100, jmp=16'hFFFE (-2) -> flush; prog_addr=3 same cycle; instr_valid=0 for one cycle; then cur_pc=3; stale response discarded.
- With AVR_PREFETCH_LONG_INSTR_EN, word[0]=16'h940C, word[1]=16'h1234 -> cur_long=1, cur_instr2=16'h1234; pc_src=011 pops both; cur_pc=2 next.
- fetch_pc=16'hFFFF -> next request is address 16'h0000; pc_src=110 -> pc_err one-cycle pulse, head held.
- RST asserted with a request in flight -> all outputs zero next cycle; first post-reset instruction is word[0].

Source files
------------

// File: rtl/avr_pkg.sv
// Shared AVR front-end definitions: pc_src control encoding, the NOP word
// and the opcode patterns that identify 32-bit (two-word) instructions.
package avr_pkg;

  // PC control selector driven by the execute stage
  typedef enum logic [2:0] {
    PC_ZERO = 3'b000,
    PC_HOLD = 3'b001,
    PC_INC1 = 3'b010,
    PC_INC2 = 3'b011,
    PC_REL  = 3'b100,
    PC_ABS  = 3'b101,
    PC_ILL6 = 3'b110,
    PC_ILL7 = 3'b111
  } pc_src_e;

  localparam logic [15:0] NOP = 16'h0000;

  // JMP/CALL: 1001010x_xxxx11xx
  localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
  localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;
  // LDS/STS: 100100xx_xxxx0000
  localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
  localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;

  // True when the word is the first half of a two-word instruction
  function automatic logic is_long_op(input logic [15:0] w);
    return ((w & JMP_CALL_MASK) == JMP_CALL_MATCH) ||
           ((w & LDS_STS_MASK)  == LDS_STS_MATCH);
  endfunction

endpackage

// File: rtl/avr_prefetch_fifo.sv
// Prefetch queue storage: circular buffer of DEPTH entries with one push
// and a pop of 0, 1 or 2 entries per cycle. Exposes the head and the entry
// behind it so a two-word instruction can be presented in one cycle.
module avr_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic [1:0]               pop_cnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      cnt;

  assign count     = cnt;
  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_ptr + PW'(1)];

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      // DEPTH is a power of two, so pointer arithmetic wraps naturally
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      cnt    <= cnt + (PW+1)'(push) - (PW+1)'(pop_cnt);
    end
  end

  // Entry storage, written at the tail
  always_ff @(posedge CLK) begin
    if (push && !RST && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/avr_prefetch.sv
// AVR instruction prefetch unit: issues sequential program-memory reads,
// queues {pc, word} responses and presents the head instruction.
// Redirects flush the queue and tag the outstanding read stale via an epoch
// bit. Optional macro AVR_PREFETCH_LONG_INSTR_EN enables two-word
// instruction (JMP/CALL/LDS/STS) detection and the +2 pop.
module avr_prefetch
  import avr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              prog_req,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [2:0]        pc_src,
  input  logic [ADDR_W-1:0] jmp,
  input  logic              stall,
  output logic              instr_valid,
  output logic [15:0]       cur_instr,
  output logic [15:0]       cur_instr2,
  output logic              cur_long,
  output logic [ADDR_W-1:0] cur_pc,
  output logic              pc_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + 16;

  pc_src_e           src;
  logic [CNT_W-1:0]  occ;
  logic [ENT_W-1:0]  head_ent;
  logic [ENT_W-1:0]  next_ent;
  logic [ENT_W-1:0]  push_ent;
  logic [ADDR_W-1:0] head_pc;
  logic [15:0]       head_word;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] target;
  logic              epoch;
  logic              inflight_v;
  logic              inflight_ep;
  logic              nonempty;
  logic              has_two;
  logic              head_long;
  logic              head_ready;
  logic              redirect;
  logic              room;
  logic              issue;
  logic              push;
  logic [1:0]        pop_cnt;

  assign src       = pc_src_e'(pc_src);
  assign head_pc   = head_ent[ENT_W-1:16];
  assign head_word = head_ent[15:0];
  assign nonempty  = (occ != '0);
  assign has_two   = (occ >= CNT_W'(2));

`ifdef AVR_PREFETCH_LONG_INSTR_EN
  assign head_long = nonempty && is_long_op(head_word);
`else
  assign head_long = 1'b0;
  logic unused_next;
  assign unused_next = ^next_ent;
`endif

  // A two-word head is only presentable once its second word has arrived
  assign head_ready = nonempty && (!head_long || has_two);

  // Decode pc_src into redirect target or pop count; redirect wins over pop
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    pop_cnt  = 2'd0;
    case (src)
      PC_ZERO: redirect = head_ready;
      PC_REL: begin
        redirect = head_ready;
        target   = head_pc + jmp;
      end
      PC_ABS: begin
        redirect = head_ready;
        target   = jmp;
      end
      PC_INC1, PC_INC2: begin
        if (head_ready && !stall) begin
          pop_cnt = head_long ? 2'd2 : 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Issue while queued plus outstanding entries leave a free slot; a
  // redirect always issues because it empties the queue and the in-flight slot
  assign room      = (occ + CNT_W'(inflight_v)) < CNT_W'(DEPTH);
  assign issue     = redirect || room;
  assign push      = inflight_v && (inflight_ep == epoch) && !redirect;
  assign push_ent  = {inflight_pc, prog_data};
  assign prog_req  = !RST && issue;
  assign prog_addr = redirect ? target : fetch_pc;

  // Fetch address, epoch and outstanding-request tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= '0;
      epoch       <= 1'b0;
      inflight_v  <= 1'b0;
      inflight_ep <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight_v  <= issue;
      inflight_ep <= redirect ? !epoch : epoch;
      inflight_pc <= prog_addr;
      if (redirect) begin
        epoch    <= !epoch;
        fetch_pc <= target + ADDR_W'(1);
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  avr_prefetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENT_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (redirect),
    .push      (push),
    .push_data (push_ent),
    .pop_cnt   (pop_cnt),
    .count     (occ),
    .head_data (head_ent),
    .next_data (next_ent)
  );

  assign instr_valid = !RST && head_ready;
  assign cur_instr   = (!RST && nonempty) ? head_word : NOP;
  assign cur_pc      = (!RST && nonempty) ? head_pc : '0;
  assign cur_long    = !RST && head_long;
  assign pc_err      = !RST && ((src == PC_ILL6) || (src == PC_ILL7));

`ifdef AVR_PREFETCH_LONG_INSTR_EN
  assign cur_instr2 = (!RST && head_long && has_two) ? next_ent[15:0] : NOP;
`else
  assign cur_instr2 = '0;
`endif

endmodule

// File: tb/tb_avr_prefetch.sv
// Self-checking bench for avr_prefetch: table-driven streaming vectors,
// directed multi-cycle sequences and a randomized run against a queue model.
module tb_avr_prefetch;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
`ifdef AVR_PREFETCH_LONG_INSTR_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              prog_req;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [2:0]        pc_src;
  logic [ADDR_W-1:0] jmp;
  logic              stall;
  logic              instr_valid;
  logic [15:0]       cur_instr;
  logic [15:0]       cur_instr2;
  logic              cur_long;
  logic [ADDR_W-1:0] cur_pc;
  logic              pc_err;

  always #5 CLK = ~CLK;

  avr_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .prog_req    (prog_req),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .pc_src      (pc_src),
    .jmp         (jmp),
    .stall       (stall),
    .instr_valid (instr_valid),
    .cur_instr   (cur_instr),
    .cur_instr2  (cur_instr2),
    .cur_long    (cur_long),
    .cur_pc      (cur_pc),
    .pc_err      (pc_err)
  );

  // Program memory: registered read, data valid the cycle after the strobe
  logic [15:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
  always @(posedge CLK) prog_data <= prog_req ? mem[prog_addr] : 16'hDEAD;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; pc_src = 3'b001; stall = 1'b0; jmp = '0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic step(input logic [2:0] s, input logic st, input logic [15:0] j);
    @(negedge CLK);
    RST = 1'b0; pc_src = s; stall = st; jmp = j;
    #1;
  endtask

  function automatic bit long_word(input logic [15:0] w);
    return LONG_EN && ((w ==? 16'b1001010?????11??) || (w ==? 16'b100100??????0000));
  endfunction

  typedef struct {
    logic [2:0]  src;
    logic        st;
    logic        ev;
    logic [15:0] epc;
    logic        er;
    logic [15:0] ea;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] w;
  } ent_t;

  vec_t tv [12];

  initial begin
    int n;
    bit found;
    ent_t q[$];
    bit pend;
    logic [15:0] pend_pc, mfpc, tgt;
    int sz, src, r;
    bit hl, ev, redir, room, er, st;
    logic [15:0] j;

    RST = 1'b1; pc_src = 3'b001; stall = 1'b0; jmp = '0;

    // Streaming from reset, then a 3-cycle stall filling the queue
    tv[0]  = '{3'b010, 1'b0, 1'b0, 16'd0, 1'b1, 16'd0};
    tv[1]  = '{3'b010, 1'b0, 1'b0, 16'd0, 1'b1, 16'd1};
    tv[2]  = '{3'b010, 1'b0, 1'b1, 16'd0, 1'b1, 16'd2};
    tv[3]  = '{3'b010, 1'b0, 1'b1, 16'd1, 1'b1, 16'd3};
    tv[4]  = '{3'b010, 1'b0, 1'b1, 16'd2, 1'b1, 16'd4};
    tv[5]  = '{3'b010, 1'b1, 1'b1, 16'd3, 1'b1, 16'd5};
    tv[6]  = '{3'b010, 1'b1, 1'b1, 16'd3, 1'b1, 16'd6};
    tv[7]  = '{3'b010, 1'b1, 1'b1, 16'd3, 1'b0, 16'd0};
    tv[8]  = '{3'b010, 1'b0, 1'b1, 16'd3, 1'b0, 16'd0};
    tv[9]  = '{3'b010, 1'b0, 1'b1, 16'd4, 1'b1, 16'd7};
    tv[10] = '{3'b010, 1'b0, 1'b1, 16'd5, 1'b1, 16'd8};
    tv[11] = '{3'b010, 1'b0, 1'b1, 16'd6, 1'b1, 16'd9};

    // Outputs while held in reset
    do_reset();
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_req",   prog_req,    1'b0);
    chk("rst_instr", cur_instr,   16'h0);
    chk("rst_instr2", cur_instr2, 16'h0);
    chk("rst_long",  cur_long,    1'b0);
    chk("rst_pc",    cur_pc,      16'h0);
    chk("rst_err",   pc_err,      1'b0);

    for (int i = 0; i < 12; i++) begin
      step(tv[i].src, tv[i].st, 16'h0);
      chk($sformatf("tv%0d_valid", i), instr_valid, tv[i].ev);
      chk($sformatf("tv%0d_req", i), prog_req, tv[i].er);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_pc", i), cur_pc, tv[i].epc);
        chk($sformatf("tv%0d_instr", i), cur_instr, tv[i].epc);
      end else begin
        chk($sformatf("tv%0d_nop", i), cur_instr, 16'h0);
      end
      if (tv[i].er) chk($sformatf("tv%0d_addr", i), prog_addr, tv[i].ea);
    end

    // Stall from reset: exactly DEPTH requests, head held, one pop on release
    do_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step(3'b010, 1'b1, 16'h0);
      if (prog_req) n++;
    end
    chk("stall_reqs", n, DEPTH);
    chk("stall_req_off", prog_req, 1'b0);
    chk("stall_valid", instr_valid, 1'b1);
    chk("stall_head", cur_pc, 16'd0);
    step(3'b010, 1'b0, 16'h0);
    chk("release_head", cur_pc, 16'd0);
    step(3'b001, 1'b0, 16'h0);
    chk("release_pop1", cur_pc, 16'd1);

    // Relative redirect from pc 5 by -2
    do_reset();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(3'b010, 1'b0, 16'h0);
      if (instr_valid && cur_pc == 16'd4) found = 1;
    end
    chk("rel_reach4", found, 1'b1);
    step(3'b100, 1'b0, 16'hFFFE);
    chk("rel_head5", cur_pc, 16'd5);
    chk("rel_req", prog_req, 1'b1);
    chk("rel_addr", prog_addr, 16'd3);
    step(3'b010, 1'b0, 16'h0);
    chk("rel_bubble", instr_valid, 1'b0);
    step(3'b010, 1'b0, 16'h0);
    chk("rel_valid", instr_valid, 1'b1);
    chk("rel_pc3", cur_pc, 16'd3);
    chk("rel_instr3", cur_instr, 16'd3);
    step(3'b010, 1'b0, 16'h0);
    chk("rel_pc4", cur_pc, 16'd4);

    // Absolute redirect to 0xFFFF: fetch wraps to 0; illegal pc_src pulses
    step(3'b101, 1'b0, 16'hFFFF);
    chk("abs_req", prog_req, 1'b1);
    chk("abs_addr", prog_addr, 16'hFFFF);
    step(3'b001, 1'b0, 16'h0);
    chk("wrap_addr", prog_addr, 16'h0000);
    chk("abs_bubble", instr_valid, 1'b0);
    step(3'b001, 1'b0, 16'h0);
    chk("abs_pc", cur_pc, 16'hFFFF);
    chk("abs_instr", cur_instr, 16'hFFFF);
    step(3'b110, 1'b0, 16'h0);
    chk("err_pulse", pc_err, 1'b1);
    step(3'b001, 1'b0, 16'h0);
    chk("err_clear", pc_err, 1'b0);
    chk("err_hold", cur_pc, 16'hFFFF);
    step(3'b111, 1'b0, 16'h0);
    chk("err7_pulse", pc_err, 1'b1);
    step(3'b010, 1'b0, 16'h0);
    chk("err7_hold", cur_pc, 16'hFFFF);
    step(3'b001, 1'b0, 16'h0);
    chk("wrap_pc0", cur_pc, 16'h0000);

`ifdef AVR_PREFETCH_LONG_INSTR_EN
    // Two-word JMP at address 0
    mem[0] = 16'h940C;
    mem[1] = 16'h1234;
    do_reset();
    step(3'b001, 1'b0, 16'h0);
    step(3'b001, 1'b0, 16'h0);
    step(3'b001, 1'b0, 16'h0);
    chk("long_wait2", instr_valid, 1'b0);
    step(3'b001, 1'b0, 16'h0);
    chk("long_valid", instr_valid, 1'b1);
    chk("long_flag", cur_long, 1'b1);
    chk("long_w1", cur_instr, 16'h940C);
    chk("long_w2", cur_instr2, 16'h1234);
    step(3'b011, 1'b0, 16'h0);
    step(3'b001, 1'b0, 16'h0);
    chk("long_next_pc", cur_pc, 16'd2);
    chk("long_next_flag", cur_long, 1'b0);
    mem[0] = 16'h0000;
    mem[1] = 16'h0001;
`endif

    // Reset with a request outstanding
    do_reset();
    step(3'b010, 1'b0, 16'h0);
    step(3'b010, 1'b0, 16'h0);
    step(3'b010, 1'b0, 16'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("mid_rst_valid", instr_valid, 1'b0);
    chk("mid_rst_req", prog_req, 1'b0);
    chk("mid_rst_instr", cur_instr, 16'h0);
    chk("mid_rst_pc", cur_pc, 16'h0);
    step(3'b010, 1'b0, 16'h0);
    chk("post_rst_req", prog_req, 1'b1);
    chk("post_rst_addr", prog_addr, 16'h0);
    step(3'b010, 1'b0, 16'h0);
    chk("post_rst_c1", instr_valid, 1'b0);
    step(3'b010, 1'b0, 16'h0);
    chk("post_rst_valid", instr_valid, 1'b1);
    chk("post_rst_pc", cur_pc, 16'h0);
    chk("post_rst_word", cur_instr, 16'h0);

    // Randomized run against a queue-level model
    do_reset();
    q.delete();
    pend = 0; pend_pc = '0; mfpc = '0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      src = (r < 50) ? 2 : (r < 60) ? 3 : (r < 72) ? 1 : (r < 76) ? 0 :
            (r < 84) ? 4 : (r < 90) ? 5 : (r < 95) ? 6 : 7;
      st = ($urandom_range(0, 3) == 0);
      j = 16'($urandom);
      step(3'(src), st, j);

      sz = q.size();
      hl = (sz > 0) && long_word(q[0].w);
      ev = (sz > 0) && (!hl || sz >= 2);
      redir = ev && (src == 0 || src == 4 || src == 5);
      tgt = '0;
      if (ev) tgt = (src == 0) ? 16'h0 : (src == 4) ? 16'(q[0].pc + j) : j;
      room = (sz + int'(pend)) < DEPTH;
      er = redir || room;

      chk("rnd_valid", instr_valid, ev);
      chk("rnd_req", prog_req, er);
      if (er) chk("rnd_addr", prog_addr, redir ? tgt : mfpc);
      chk("rnd_err", pc_err, src >= 6);
      chk("rnd_long", cur_long, hl);
      if (ev) begin
        chk("rnd_pc", cur_pc, q[0].pc);
        chk("rnd_instr", cur_instr, q[0].w);
        if (hl) chk("rnd_instr2", cur_instr2, q[1].w);
      end
      if (sz == 0) chk("rnd_nop", cur_instr, 16'h0);

      if (redir) begin
        q.delete();
        pend = 1;
        pend_pc = tgt;
        mfpc = tgt + 16'd1;
      end else begin
        if (ev && !st && (src == 2 || src == 3)) begin
          void'(q.pop_front());
          if (hl) void'(q.pop_front());
        end
        if (pend) q.push_back('{pend_pc, mem[pend_pc]});
        pend = room;
        if (room) begin
          pend_pc = mfpc;
          mfpc = mfpc + 16'd1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
